// File: rtl/btn_ctrl_pkg.sv
// Shared types and sizing helpers for the Pong button input path.
// Used by btn_ctrl and btn_channel (BTN_AUTOREPEAT_EN adds auto-repeat).
package pong_input_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_Q,
    HELD,
    REL_Q
  } btn_state_e;

  localparam int STABLE_CNT_DEF  = 10;
  localparam int REPEAT_DLY_DEF  = 400;
  localparam int REPEAT_RATE_DEF = 50;

  localparam int CNT_W = $clog2(STABLE_CNT_DEF + 1);
  localparam int RPT_W = $clog2(REPEAT_DLY_DEF + 1);

  function automatic int cnt_width(input int v);
    return $clog2(v + 1);
  endfunction

endpackage

// File: rtl/btn_ctrl_if.sv
// Button bus between the synchronizers/game logic and btn_ctrl.
// master drives the synchronized pins, slave is the controller.
interface btn_ctrl_if #(
  parameter int N = 4
);
  logic [N-1:0] btn_sync;
  logic [N-1:0] btn_level;
  logic [N-1:0] btn_press;
  logic [N-1:0] btn_release;
  logic         sample_tick;

  modport master (
    output btn_sync,
    input  btn_level,
    input  btn_press,
    input  btn_release,
    input  sample_tick
  );

  modport slave (
    input  btn_sync,
    output btn_level,
    output btn_press,
    output btn_release,
    output sample_tick
  );
endinterface

// File: rtl/btn_ctrl_channel.sv
// One button qualification FSM; advances only on sample ticks.
// BTN_AUTOREPEAT_EN adds a repeat counter that re-fires press.
module btn_channel
  import pong_input_pkg::*;
#(
  parameter int STABLE_CNT  = STABLE_CNT_DEF,
  parameter int REPEAT_DLY  = REPEAT_DLY_DEF,
  parameter int REPEAT_RATE = REPEAT_RATE_DEF,
  parameter int CW          = CNT_W,
  parameter int RW          = RPT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic tick_i,
  input  logic in_i,
  output logic level_o,
  output logic press_o,
  output logic release_o
);

  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CNT);
  localparam bit ONE_TICK = (STABLE_CNT == 1);

  if (STABLE_CNT < 1 || STABLE_CNT > 255 || CW < 1) begin : g_bad_cnt
    $error("btn_channel: STABLE_CNT out of range");
  end

  // Repeat reload is DLY-RATE, so the rate may not exceed the delay.
  if (RW < 1 || REPEAT_RATE < 1 || REPEAT_RATE > REPEAT_DLY) begin : g_bad_rpt
    $error("btn_channel: bad repeat configuration");
  end

  btn_state_e    st_q;
  logic [CW-1:0] cnt_q;
  logic          level_q;
  logic          press_q;
  logic          release_q;

  logic [CW-1:0] cnt_inc;
  logic          hit;

  assign cnt_inc = cnt_q + CW'(1);
  assign hit     = (cnt_inc == CNT_MAX);

`ifdef BTN_AUTOREPEAT_EN
  localparam logic [RW-1:0] RPT_FIRE = RW'(REPEAT_DLY);
  localparam logic [RW-1:0] RPT_RLD  = RW'(REPEAT_DLY - REPEAT_RATE);

  logic [RW-1:0] rpt_q;
  logic [RW-1:0] rpt_inc;
  logic          leave;

  assign rpt_inc = rpt_q + RW'(1);
  assign leave   = !in_i &&
                   ((st_q == HELD && ONE_TICK) ||
                    (st_q == REL_Q && hit));
`endif

  // Qualification FSM with registered level and one-cycle pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q      <= IDLE;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
      rpt_q     <= '0;
`endif
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      if (tick_i) begin
        unique case (st_q)
          IDLE: begin
            if (in_i) begin
              if (ONE_TICK) begin
                st_q    <= HELD;
                cnt_q   <= '0;
                level_q <= 1'b1;
                press_q <= 1'b1;
              end else begin
                st_q  <= PRESS_Q;
                cnt_q <= CW'(1);
              end
            end
          end
          PRESS_Q: begin
            if (!in_i) begin
              st_q  <= IDLE;
              cnt_q <= '0;
            end else if (hit) begin
              st_q    <= HELD;
              cnt_q   <= '0;
              level_q <= 1'b1;
              press_q <= 1'b1;
            end else begin
              cnt_q <= cnt_inc;
            end
          end
          HELD: begin
            if (!in_i) begin
              if (ONE_TICK) begin
                st_q      <= IDLE;
                cnt_q     <= '0;
                level_q   <= 1'b0;
                release_q <= 1'b1;
              end else begin
                st_q  <= REL_Q;
                cnt_q <= CW'(1);
              end
            end
          end
          REL_Q: begin
            if (in_i) begin
              st_q  <= HELD;
              cnt_q <= '0;
            end else if (hit) begin
              st_q      <= IDLE;
              cnt_q     <= '0;
              level_q   <= 1'b0;
              release_q <= 1'b1;
            end else begin
              cnt_q <= cnt_inc;
            end
          end
          default: begin
            st_q  <= IDLE;
            cnt_q <= '0;
          end
        endcase
`ifdef BTN_AUTOREPEAT_EN
        // Repeat count runs while the level is high; cleared otherwise.
        if ((st_q == HELD || st_q == REL_Q) && !leave) begin
          if (rpt_inc == RPT_FIRE) begin
            press_q <= 1'b1;
            rpt_q   <= RPT_RLD;
          end else begin
            rpt_q <= rpt_inc;
          end
        end else begin
          rpt_q <= '0;
        end
`endif
      end
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

// File: rtl/btn_ctrl.sv
// Pong button controller: shared sample prescaler + N channels.
// Define BTN_AUTOREPEAT_EN to enable press auto-repeat.
module btn_ctrl
  import pong_input_pkg::*;
#(
  parameter int N_BTN       = 4,
  parameter int CLK_HZ      = 100_000_000,
  parameter int SAMPLE_HZ   = 1_000,
  parameter int STABLE_CNT  = STABLE_CNT_DEF,
  parameter int REPEAT_DLY  = REPEAT_DLY_DEF,
  parameter int REPEAT_RATE = REPEAT_RATE_DEF
) (
  input logic       clk,
  input logic       rst,
  btn_ctrl_if.slave bus
);

  localparam int DIV = CLK_HZ / SAMPLE_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] LAST     = PW'(DIV - 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 2);

  if (DIV < 2) begin : g_bad_div
    $error("btn_ctrl: CLK_HZ/SAMPLE_HZ must be at least 2");
  end

  logic [PW-1:0] pre_q;
  logic [PW-1:0] pre_d;
  logic          tick_q;
  logic          tick_d;

  // Tick is registered, so it is computed one count early.
  always_comb begin
    pre_d  = (pre_q == LAST) ? '0 : pre_q + PW'(1);
    tick_d = (pre_q == PRE_LAST);
  end

  // Prescaler and sample strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      tick_q <= tick_d;
    end
  end

  logic [N_BTN-1:0] lvl;
  logic [N_BTN-1:0] prs;
  logic [N_BTN-1:0] rel;

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_channel #(
      .STABLE_CNT  (STABLE_CNT),
      .REPEAT_DLY  (REPEAT_DLY),
      .REPEAT_RATE (REPEAT_RATE),
      .CW          (cnt_width(STABLE_CNT)),
      .RW          (cnt_width(REPEAT_DLY))
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .tick_i    (tick_q),
      .in_i      (bus.btn_sync[i]),
      .level_o   (lvl[i]),
      .press_o   (prs[i]),
      .release_o (rel[i])
    );
  end

  assign bus.btn_level   = lvl;
  assign bus.btn_press   = prs;
  assign bus.btn_release = rel;
  assign bus.sample_tick = tick_q;

endmodule
